// File: rtl/stream_skid_pkg.sv
// Shared types for the stream skid buffer: FSM state encoding and storage depth.
package stream_skid_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        BUSY  = 2'b01,
        FULL  = 2'b10
    } skid_state_e;

    localparam int unsigned SkidDepth = 2;

    // Number of beats held in each state.
    function automatic int unsigned skid_occupancy(input skid_state_e s);
        unique case (s)
            EMPTY:   return 0;
            BUSY:    return 1;
            FULL:    return SkidDepth;
            default: return 0;
        endcase
    endfunction

endpackage

// File: rtl/stream_skid_stats.sv
// Saturating stall-cycle counter with synchronous clear.
// Compiled only when STREAM_SKID_BUFFER_STATS_EN is defined.
`ifdef STREAM_SKID_BUFFER_STATS_EN
module stream_skid_stats #(
    parameter int unsigned CntWidth = 16
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                clr_i,
    input  logic                inc_i,
    output logic [CntWidth-1:0] cnt_o
);

    logic [CntWidth-1:0] r_cnt;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_cnt <= '0;
        end else if (clr_i) begin
            r_cnt <= '0;
        end else if (inc_i && (r_cnt != '1)) begin
            r_cnt <= r_cnt + CntWidth'(1);
        end
    end

    assign cnt_o = r_cnt;

endmodule
`endif

// File: rtl/stream_skid_buffer.sv
// Two-entry ready/valid stage with registered valid_o and ready_o (no ready_i->ready_o path).
// Optional stall counter on stall_cnt_o when STREAM_SKID_BUFFER_STATS_EN is defined.
module stream_skid_buffer
    import stream_skid_pkg::*;
#(
    parameter type T = logic
`ifdef STREAM_SKID_BUFFER_STATS_EN
    ,
    parameter int unsigned CntWidth = 16
`endif
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                clr_i,
    input  logic                valid_i,
    output logic                ready_o,
    input  T                    data_i,
    output logic                valid_o,
    input  logic                ready_i,
    output T                    data_o
`ifdef STREAM_SKID_BUFFER_STATS_EN
    ,
    output logic [CntWidth-1:0] stall_cnt_o
`endif
);

    skid_state_e r_state;
    skid_state_e w_state_d;
    T            r_main;
    T            r_skid;
    logic        r_valid;
    logic        r_ready;
    logic        w_in_hs;
    logic        w_out_hs;
    logic        w_main_en;
    logic        w_main_from_skid;
    logic        w_skid_en;

    assign w_in_hs  = valid_i & r_ready;
    assign w_out_hs = r_valid & ready_i;

    always_comb begin
        w_state_d        = r_state;
        w_main_en        = 1'b0;
        w_main_from_skid = 1'b0;
        w_skid_en        = 1'b0;
        unique case (r_state)
            EMPTY: begin
                if (w_in_hs) begin
                    w_main_en = 1'b1;
                    w_state_d = BUSY;
                end
            end
            BUSY: begin
                if (w_in_hs && w_out_hs) begin
                    w_main_en = 1'b1;
                end else if (w_in_hs) begin
                    w_skid_en = 1'b1;
                    w_state_d = FULL;
                end else if (w_out_hs) begin
                    w_state_d = EMPTY;
                end
            end
            FULL: begin
                if (w_out_hs) begin
                    w_main_en        = 1'b1;
                    w_main_from_skid = 1'b1;
                    w_state_d        = BUSY;
                end
            end
            default: w_state_d = EMPTY;
        endcase
        // Clear wins over any same-cycle handshake; captured beats are dropped.
        if (clr_i) begin
            w_state_d = EMPTY;
            w_main_en = 1'b0;
            w_skid_en = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= EMPTY;
            r_valid <= 1'b0;
            r_ready <= 1'b1;
            r_main  <= '0;
            r_skid  <= '0;
        end else begin
            r_state <= w_state_d;
            // Handshake flags are registered from the next state, so they never see ready_i.
            r_valid <= (skid_occupancy(w_state_d) != 0);
            r_ready <= (skid_occupancy(w_state_d) < SkidDepth);
            if (w_main_en) begin
                r_main <= w_main_from_skid ? r_skid : data_i;
            end
            if (w_skid_en) begin
                r_skid <= data_i;
            end
        end
    end

    assign valid_o = r_valid;
    assign ready_o = r_ready;
    assign data_o  = r_main;

`ifdef STREAM_SKID_BUFFER_STATS_EN
    stream_skid_stats #(
        .CntWidth(CntWidth)
    ) u_stats (
        .clk_i (clk_i),
        .rst_ni(rst_ni),
        .clr_i (clr_i),
        .inc_i (r_valid & ~ready_i),
        .cnt_o (stall_cnt_o)
    );
`endif

endmodule

// File: tb/tb_stream_skid_buffer.sv
// Bench for stream_skid_buffer: queue-based reference model plus directed literal checks.
// Exercises the stall counter when STREAM_SKID_BUFFER_STATS_EN is defined.
module tb_stream_skid_buffer;

    logic       clk;
    logic       rst_n;
    logic       clr_i;
    logic       valid_i;
    logic       ready_o;
    logic [7:0] data_i;
    logic       valid_o;
    logic       ready_i;
    logic [7:0] data_o;
`ifdef STREAM_SKID_BUFFER_STATS_EN
    logic [15:0] stall_cnt;
    logic [1:0]  stall_cnt2;
    logic        ready2;
    logic        valid2;
    logic [7:0]  data2;
`endif

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    bit          cmp_en   = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    stream_skid_buffer #(
        .T(logic [7:0])
`ifdef STREAM_SKID_BUFFER_STATS_EN
        ,
        .CntWidth(16)
`endif
    ) u_dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .clr_i  (clr_i),
        .valid_i(valid_i),
        .ready_o(ready_o),
        .data_i (data_i),
        .valid_o(valid_o),
        .ready_i(ready_i),
        .data_o (data_o)
`ifdef STREAM_SKID_BUFFER_STATS_EN
        ,
        .stall_cnt_o(stall_cnt)
`endif
    );

`ifdef STREAM_SKID_BUFFER_STATS_EN
    stream_skid_buffer #(
        .T(logic [7:0]),
        .CntWidth(2)
    ) u_dut2 (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .clr_i      (clr_i),
        .valid_i    (valid_i),
        .ready_o    (ready2),
        .data_i     (data_i),
        .valid_o    (valid2),
        .ready_i    (ready_i),
        .data_o     (data2),
        .stall_cnt_o(stall_cnt2)
    );
`endif

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a FIFO of at most two beats; outputs follow from its occupancy.
    logic [7:0]  m_q[$];
    int unsigned m_stall;
    int unsigned m_stall2;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_q.delete();
            m_stall  = 0;
            m_stall2 = 0;
        end else begin
            automatic bit stalled = (m_q.size() > 0) && !ready_i;
            automatic bit in_hs   = valid_i && (m_q.size() < 2);
            automatic bit out_hs  = (m_q.size() > 0) && ready_i;
            if (clr_i) begin
                m_q.delete();
                m_stall  = 0;
                m_stall2 = 0;
            end else begin
                if (out_hs) void'(m_q.pop_front());
                if (in_hs) m_q.push_back(data_i);
                if (stalled && m_stall < 65535) m_stall++;
                if (stalled && m_stall2 < 3) m_stall2++;
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && cmp_en) begin
            chk("model valid_o", 32'(valid_o), 32'(m_q.size() != 0));
            chk("model ready_o", 32'(ready_o), 32'(m_q.size() < 2));
            if (m_q.size() != 0) chk("model data_o", 32'(data_o), 32'(m_q[0]));
`ifdef STREAM_SKID_BUFFER_STATS_EN
            chk("model stall_cnt_o", 32'(stall_cnt), m_stall);
            chk("model stall_cnt_o w2", 32'(stall_cnt2), m_stall2);
`endif
        end
    end

    task automatic step(input logic v, input logic [7:0] d, input logic r, input logic c);
        valid_i = v;
        data_i  = d;
        ready_i = r;
        clr_i   = c;
        @(posedge clk);
        #2;
    endtask

    task automatic expect_out(input string name, input logic v, input logic rdy,
                              input logic [7:0] d);
        chk({name, " valid_o"}, 32'(valid_o), 32'(v));
        chk({name, " ready_o"}, 32'(ready_o), 32'(rdy));
        if (v) chk({name, " data_o"}, 32'(data_o), 32'(d));
    endtask

    initial begin
        rst_n   = 1'b0;
        clr_i   = 1'b0;
        valid_i = 1'b0;
        data_i  = 8'h00;
        ready_i = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #2;

        // Reset state
        chk("reset valid_o", 32'(valid_o), 32'd0);
        chk("reset ready_o", 32'(ready_o), 32'd1);
        chk("reset data_o", 32'(data_o), 32'd0);
`ifdef STREAM_SKID_BUFFER_STATS_EN
        chk("reset stall_cnt_o", 32'(stall_cnt), 32'd0);
`endif
        cmp_en = 1'b1;

        // Back-to-back stream, each beat visible one cycle after its handshake
        for (int k = 1; k <= 16; k++) begin
            step(1'b1, 8'(k), 1'b1, 1'b0);
            expect_out("stream", 1'b1, 1'b1, 8'(k));
        end
        step(1'b0, 8'h00, 1'b1, 1'b0);
        expect_out("stream drain", 1'b0, 1'b1, 8'h00);

        // Fill to FULL under backpressure, then drain
        step(1'b1, 8'h0A, 1'b0, 1'b0);
        expect_out("bp first", 1'b1, 1'b1, 8'h0A);
        step(1'b1, 8'h0B, 1'b0, 1'b0);
        expect_out("bp full", 1'b1, 1'b0, 8'h0A);
        step(1'b1, 8'h0C, 1'b0, 1'b0);
        expect_out("bp hold", 1'b1, 1'b0, 8'h0A);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        expect_out("bp drain A", 1'b1, 1'b1, 8'h0B);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        expect_out("bp drain B", 1'b0, 1'b1, 8'h00);

        // Clear while FULL with ready_i high
        step(1'b1, 8'h11, 1'b0, 1'b0);
        step(1'b1, 8'h22, 1'b0, 1'b0);
        expect_out("pre-clr", 1'b1, 1'b0, 8'h11);
        step(1'b1, 8'h33, 1'b1, 1'b1);
        expect_out("clr", 1'b0, 1'b1, 8'h00);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        expect_out("post-clr", 1'b0, 1'b1, 8'h00);

`ifdef STREAM_SKID_BUFFER_STATS_EN
        step(1'b0, 8'h00, 1'b0, 1'b1);
        step(1'b1, 8'h05, 1'b0, 1'b0);
        chk("stall start", 32'(stall_cnt), 32'd0);
        repeat (5) step(1'b0, 8'h00, 1'b0, 1'b0);
        chk("stall 5", 32'(stall_cnt), 32'd5);
        repeat (5) step(1'b0, 8'h00, 1'b0, 1'b0);
        chk("stall 10", 32'(stall_cnt), 32'd10);
        chk("stall sat w2", 32'(stall_cnt2), 32'd3);
        step(1'b0, 8'h00, 1'b1, 1'b1);
        chk("stall clr", 32'(stall_cnt), 32'd0);
`endif

        // Asynchronous reset in the middle of a transfer
        step(1'b1, 8'h44, 1'b0, 1'b0);
        step(1'b1, 8'h55, 1'b0, 1'b0);
        valid_i = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        chk("async rst valid_o", 32'(valid_o), 32'd0);
        chk("async rst ready_o", 32'(ready_o), 32'd1);
        chk("async rst data_o", 32'(data_o), 32'd0);
        @(negedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #2;

        // Random traffic checked cycle by cycle against the model
        for (int i = 0; i < 10000; i++) begin
            step(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
                 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 63) == 0));
        end
        step(1'b0, 8'h00, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        expect_out("final drain", 1'b0, 1'b1, 8'h00);

        cmp_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
